rs_mul: RTL and testbench

RS_MUL -- requirements
Module: rs_mul

---
 rtl/rs_mul_pkg.sv | 15 +
 rtl/rs_mul_sel.sv | 23 ++
 rtl/rs_mul.sv | 203 ++++++++++++++++++++
 tb/tb_rs_mul.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_mul_pkg.sv
// Shared types and constants for the multiplier reservation station.
// Optional dispatch-time CDB bypass is enabled by RS_MUL_BYPASS_EN.
package rs_mul_pkg;

    localparam int TAG_W_DEF = 3;
    localparam int TAG_NONE  = 0;
    localparam int DATA_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

endpackage

// File: rtl/rs_mul_sel.sv
// Lowest-index priority encoder over an N-bit request vector.
// Used for both free-slot and ready-entry selection.
module rs_mul_sel #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_o = 1'b1;
                idx_o   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/rs_mul.sv
// Reservation station feeding a single multiplier unit.
// Define RS_MUL_BYPASS_EN to capture a colliding CDB broadcast at dispatch.
module rs_mul
    import rs_mul_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [TAG_W-1:0]  iss_dst,
    input  logic [DATA_W-1:0] iss_vj,
    input  logic [DATA_W-1:0] iss_vk,
    input  logic [TAG_W-1:0]  iss_qj,
    input  logic [TAG_W-1:0]  iss_qk,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              fu_en,
    output logic [DATA_W-1:0] fu_a,
    output logic [DATA_W-1:0] fu_b,
    input  logic              fu_finish,
    input  logic [DATA_W-1:0] fu_res,
    output logic              wb_valid,
    output logic [TAG_W-1:0]  wb_tag,
    output logic [DATA_W-1:0] wb_data,
    input  logic              wb_grant
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [TAG_W-1:0] TNONE = TAG_W'(TAG_NONE);

    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [TAG_W-1:0]  dst_q [DEPTH];
    logic [TAG_W-1:0]  dst_d [DEPTH];
    logic [TAG_W-1:0]  qj_q  [DEPTH];
    logic [TAG_W-1:0]  qj_d  [DEPTH];
    logic [TAG_W-1:0]  qk_q  [DEPTH];
    logic [TAG_W-1:0]  qk_d  [DEPTH];
    logic [DATA_W-1:0] vj_q  [DEPTH];
    logic [DATA_W-1:0] vj_d  [DEPTH];
    logic [DATA_W-1:0] vk_q  [DEPTH];
    logic [DATA_W-1:0] vk_d  [DEPTH];

    state_e            state_q, state_d;
    logic [DATA_W-1:0] fu_a_q, fu_a_d;
    logic [DATA_W-1:0] fu_b_q, fu_b_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [TAG_W-1:0]  wb_tag_q, wb_tag_d;

    logic [DEPTH-1:0]  rdy_vec;
    logic              free_found, rdy_found;
    logic [IW-1:0]     free_idx, rdy_idx;
    logic              accept, issue;
    logic              hit_j, hit_k;
    logic              cdb_hit;
    logic [TAG_W-1:0]  in_qj, in_qk;
    logic [DATA_W-1:0] in_vj, in_vk;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = busy_q[i]
                      && (qj_q[i] == TNONE)
                      && (qk_q[i] == TNONE);
        end
    end

    rs_mul_sel #(.N(DEPTH), .IW(IW)) u_free (
        .req_i   (~busy_q),
        .found_o (free_found),
        .idx_o   (free_idx)
    );

    rs_mul_sel #(.N(DEPTH), .IW(IW)) u_rdy (
        .req_i   (rdy_vec),
        .found_o (rdy_found),
        .idx_o   (rdy_idx)
    );

    assign iss_ready = free_found;
    assign accept    = iss_valid && free_found;
    assign issue     = (state_q == ST_IDLE) && rdy_found;
    assign cdb_hit   = cdb_valid && (cdb_tag != TNONE);

`ifdef RS_MUL_BYPASS_EN
    assign hit_j = cdb_hit && (iss_qj == cdb_tag);
    assign hit_k = cdb_hit && (iss_qk == cdb_tag);
`else
    assign hit_j = 1'b0;
    assign hit_k = 1'b0;
`endif

    assign in_qj = hit_j ? TNONE : iss_qj;
    assign in_qk = hit_k ? TNONE : iss_qk;
    assign in_vj = hit_j ? cdb_data : iss_vj;
    assign in_vk = hit_k ? cdb_data : iss_vk;

    // Issue selects a busy entry, dispatch a free one: never the same slot.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            dst_d[i] = dst_q[i];
            qj_d[i]  = qj_q[i];
            qk_d[i]  = qk_q[i];
            vj_d[i]  = vj_q[i];
            vk_d[i]  = vk_q[i];
            if (busy_q[i] && cdb_hit) begin
                if (qj_q[i] == cdb_tag) begin
                    qj_d[i] = TNONE;
                    vj_d[i] = cdb_data;
                end
                if (qk_q[i] == cdb_tag) begin
                    qk_d[i] = TNONE;
                    vk_d[i] = cdb_data;
                end
            end
        end
        if (issue) begin
            busy_d[rdy_idx] = 1'b0;
        end
        if (accept) begin
            busy_d[free_idx] = 1'b1;
            dst_d[free_idx]  = iss_dst;
            qj_d[free_idx]   = in_qj;
            qk_d[free_idx]   = in_qk;
            vj_d[free_idx]   = in_vj;
            vk_d[free_idx]   = in_vk;
        end
    end

    always_comb begin
        state_d   = state_q;
        fu_a_d    = fu_a_q;
        fu_b_d    = fu_b_q;
        wb_data_d = wb_data_q;
        wb_tag_d  = wb_tag_q;
        unique case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    fu_a_d   = vj_q[rdy_idx];
                    fu_b_d   = vk_q[rdy_idx];
                    wb_tag_d = dst_q[rdy_idx];
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (fu_finish) begin
                    wb_data_d = fu_res;
                    state_d   = ST_WB;
                end
            end
            ST_WB: begin
                if (wb_grant) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            state_q   <= ST_IDLE;
            fu_a_q    <= '0;
            fu_b_q    <= '0;
            wb_data_q <= '0;
            wb_tag_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                dst_q[i] <= '0;
                qj_q[i]  <= '0;
                qk_q[i]  <= '0;
                vj_q[i]  <= '0;
                vk_q[i]  <= '0;
            end
        end else begin
            busy_q    <= busy_d;
            state_q   <= state_d;
            fu_a_q    <= fu_a_d;
            fu_b_q    <= fu_b_d;
            wb_data_q <= wb_data_d;
            wb_tag_q  <= wb_tag_d;
            for (int i = 0; i < DEPTH; i++) begin
                dst_q[i] <= dst_d[i];
                qj_q[i]  <= qj_d[i];
                qk_q[i]  <= qk_d[i];
                vj_q[i]  <= vj_d[i];
                vk_q[i]  <= vk_d[i];
            end
        end
    end

    // Operands are visible in the issue cycle, then held from the latch.
    assign fu_en    = issue;
    assign fu_a     = issue ? vj_q[rdy_idx] : fu_a_q;
    assign fu_b     = issue ? vk_q[rdy_idx] : fu_b_q;
    assign wb_valid = (state_q == ST_WB);
    assign wb_tag   = wb_tag_q;
    assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_rs_mul.sv
// Self-checking bench for rs_mul against a behavioural entry-table model.
module tb_rs_mul;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iss_valid, iss_ready;
    logic [2:0]  iss_dst, iss_qj, iss_qk;
    logic [31:0] iss_vj, iss_vk;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        fu_en, fu_finish;
    logic [31:0] fu_a, fu_b, fu_res;
    logic        wb_valid, wb_grant;
    logic [2:0]  wb_tag;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_fail = 0;
    bit go = 1'b0;

    rs_mul #(.DEPTH(D), .TAG_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_dst   (iss_dst),
        .iss_vj    (iss_vj),
        .iss_vk    (iss_vk),
        .iss_qj    (iss_qj),
        .iss_qk    (iss_qk),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data),
        .fu_en     (fu_en),
        .fu_a      (fu_a),
        .fu_b      (fu_b),
        .fu_finish (fu_finish),
        .fu_res    (fu_res),
        .wb_valid  (wb_valid),
        .wb_tag    (wb_tag),
        .wb_data   (wb_data),
        .wb_grant  (wb_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a table of pending ops and a 3-phase unit.
    int          m_busy [D];
    int          m_dst  [D];
    int          m_qj   [D];
    int          m_qk   [D];
    logic [31:0] m_vj   [D];
    logic [31:0] m_vk   [D];
    int          m_phase;
    logic [31:0] m_a, m_b, m_data;
    int          m_tag;

    function automatic int low_ready();
        for (int i = 0; i < D; i++)
            if (m_busy[i] != 0 && m_qj[i] == 0 && m_qk[i] == 0)
                return i;
        return -1;
    endfunction

    function automatic int low_free();
        for (int i = 0; i < D; i++)
            if (m_busy[i] == 0) return i;
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int r, f;
        if (!rst_n) begin
            for (int i = 0; i < D; i++) m_busy[i] = 0;
            m_phase = 0;
            m_a = 0; m_b = 0; m_data = 0; m_tag = 0;
        end else begin
            r = low_ready();
            f = low_free();
            if (cdb_valid && cdb_tag != 0) begin
                for (int i = 0; i < D; i++) begin
                    if (m_busy[i] != 0 && m_qj[i] == int'(cdb_tag)) begin
                        m_qj[i] = 0; m_vj[i] = cdb_data;
                    end
                    if (m_busy[i] != 0 && m_qk[i] == int'(cdb_tag)) begin
                        m_qk[i] = 0; m_vk[i] = cdb_data;
                    end
                end
            end
            if (m_phase == 0 && r >= 0) begin
                m_a = m_vj[r]; m_b = m_vk[r]; m_tag = m_dst[r];
                m_busy[r] = 0;
                m_phase = 1;
            end else if (m_phase == 1 && fu_finish) begin
                m_data = fu_res;
                m_phase = 2;
            end else if (m_phase == 2 && wb_grant) begin
                m_phase = 0;
            end
            if (iss_valid && f >= 0) begin
                m_busy[f] = 1;
                m_dst[f] = int'(iss_dst);
                m_qj[f] = int'(iss_qj); m_vj[f] = iss_vj;
                m_qk[f] = int'(iss_qk); m_vk[f] = iss_vk;
`ifdef RS_MUL_BYPASS_EN
                if (cdb_valid && cdb_tag != 0) begin
                    if (iss_qj == cdb_tag) begin
                        m_qj[f] = 0; m_vj[f] = cdb_data;
                    end
                    if (iss_qk == cdb_tag) begin
                        m_qk[f] = 0; m_vk[f] = cdb_data;
                    end
                end
`endif
            end
        end
    end

    always @(negedge clk) begin : compare
        int r;
        bit en;
        if (go) begin
            r = low_ready();
            en = (m_phase == 0) && (r >= 0);
            chk("iss_ready", 32'(iss_ready), 32'(low_free() >= 0));
            chk("fu_en", 32'(fu_en), 32'(en));
            if (en) begin
                chk("fu_a_issue", fu_a, m_vj[r]);
                chk("fu_b_issue", fu_b, m_vk[r]);
            end else if (m_phase == 1) begin
                chk("fu_a_hold", fu_a, m_a);
                chk("fu_b_hold", fu_b, m_b);
            end
            chk("wb_valid", 32'(wb_valid), 32'(m_phase == 2));
            if (m_phase == 2) begin
                chk("wb_tag", 32'(wb_tag), 32'(m_tag));
                chk("wb_data", wb_data, m_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input int dst, input int vj, input int qj,
                            input int vk, input int qk);
        iss_valid = 1'b1;
        iss_dst = 3'(dst); iss_vj = vj; iss_qj = 3'(qj);
        iss_vk = vk; iss_qk = 3'(qk);
        tick();
        iss_valid = 1'b0;
    endtask

    task automatic cdb(input int tag, input int data);
        cdb_valid = 1'b1; cdb_tag = 3'(tag); cdb_data = data;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic complete(input int res);
        fu_finish = 1'b1; fu_res = res;
        tick();
        fu_finish = 1'b0;
        wb_grant = 1'b1;
        tick();
        wb_grant = 1'b0;
    endtask

    task automatic wait_en(input int max);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            @(negedge clk);
            if (fu_en) seen = 1'b1;
            else if (i < max - 1) tick();
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL wait_fu_en: no fu_en in %0d cycles", max);
        end
    endtask

    initial begin
        iss_valid = 0; iss_dst = 0; iss_vj = 0; iss_vk = 0;
        iss_qj = 0; iss_qk = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
        fu_finish = 0; fu_res = 0; wb_grant = 0;
        tick();
        go = 1'b1;
        @(negedge clk);
        chk("rst_fu_en", 32'(fu_en), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_iss_ready", 32'(iss_ready), 1);
        chk("rst_fu_a", fu_a, 0);
        chk("rst_fu_b", fu_b, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_wb_tag", 32'(wb_tag), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // Basic op: 3*5 -> tag 1
        dispatch(1, 3, 0, 5, 0);
        @(negedge clk);
        chk("t1_fu_en", 32'(fu_en), 1);
        chk("t1_fu_a", fu_a, 3);
        chk("t1_fu_b", fu_b, 5);
        tick();
        @(negedge clk);
        chk("t1_en_low", 32'(fu_en), 0);
        chk("t1_a_hold", fu_a, 3);
        fu_finish = 1'b1; fu_res = 15;
        tick();
        fu_finish = 1'b0;
        dispatch(2, 6, 0, 7, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t1_wb_valid", 32'(wb_valid), 1);
            chk("t1_wb_tag", 32'(wb_tag), 1);
            chk("t1_wb_data", wb_data, 15);
            chk("t1_no_en", 32'(fu_en), 0);
            tick();
        end
        wb_grant = 1'b1;
        tick();
        wb_grant = 1'b0;
        @(negedge clk);
        chk("t1_wb_drop", 32'(wb_valid), 0);
        chk("t1_reissue", 32'(fu_en), 1);
        chk("t1_re_a", fu_a, 6);
        tick();
        complete(42);

        // Wake by CDB
        dispatch(3, 0, 2, 7, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("t2_wait", 32'(fu_en), 0);
            tick();
        end
        cdb(2, 4);
        @(negedge clk);
        chk("t2_fu_en", 32'(fu_en), 1);
        chk("t2_fu_a", fu_a, 4);
        chk("t2_fu_b", fu_b, 7);
        tick();
        complete(28);

        // Full station, in-order issue
        for (int k = 0; k < 4; k++) dispatch(k + 1, 0, 5, 10 + k, 0);
        @(negedge clk);
        chk("t3_full", 32'(iss_ready), 0);
        tick();
        dispatch(7, 100, 0, 100, 0);
        cdb(5, 2);
        for (int k = 0; k < 4; k++) begin
            wait_en(8);
            chk("t3_order_b", fu_b, 32'(10 + k));
            chk("t3_order_a", fu_a, 2);
            tick();
            complete(20 + 2 * k);
        end
        repeat (3) begin
            @(negedge clk);
            chk("t3_drained", 32'(fu_en), 0);
            tick();
        end

        // Dispatch colliding with CDB broadcast
        iss_valid = 1'b1; iss_dst = 6; iss_qj = 3; iss_vj = 0;
        iss_vk = 1; iss_qk = 0;
        cdb_valid = 1'b1; cdb_tag = 3; cdb_data = 9;
        tick();
        iss_valid = 1'b0; cdb_valid = 1'b0;
`ifdef RS_MUL_BYPASS_EN
        @(negedge clk);
        chk("t4_bypass_en", 32'(fu_en), 1);
        chk("t4_bypass_a", fu_a, 9);
`else
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_missed", 32'(fu_en), 0);
            tick();
        end
        cdb(3, 9);
        @(negedge clk);
        chk("t4_late_en", 32'(fu_en), 1);
        chk("t4_late_a", fu_a, 9);
`endif
        tick();
        complete(9);

        // Own result on CDB wakes a dependent
        dispatch(4, 2, 0, 3, 0);
        dispatch(5, 0, 4, 10, 0);
        fu_finish = 1'b1; fu_res = 6;
        tick();
        fu_finish = 1'b0;
        wb_grant = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 4; cdb_data = 6;
        tick();
        wb_grant = 1'b0; cdb_valid = 1'b0;
        @(negedge clk);
        chk("t5_fu_en", 32'(fu_en), 1);
        chk("t5_fu_a", fu_a, 6);
        chk("t5_fu_b", fu_b, 10);
        tick();
        complete(60);

        // Reset during EXEC, then stray finish
        dispatch(2, 8, 0, 8, 0);
        tick();
        dispatch(3, 1, 0, 1, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_ready", 32'(iss_ready), 1);
        chk("t6_rst_en", 32'(fu_en), 0);
        chk("t6_rst_wb", 32'(wb_valid), 0);
        tick();
        rst_n = 1'b1;
        tick();
        fu_finish = 1'b1; fu_res = 77;
        tick();
        fu_finish = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("t6_stray_wb", 32'(wb_valid), 0);
            chk("t6_ready", 32'(iss_ready), 1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
